// File: rtl/sram_march_bist.sv
// March C- self-test engine for a single-port SRAM: one op per cycle, read data
// compared the cycle after the macro registers it, first failure kept sticky.
module sram_march_bist #(
    parameter int unsigned       ADDR_W       = 6,
    parameter int unsigned       DATA_W       = 34,
    parameter int unsigned       DEPTH        = 64,
    parameter logic [DATA_W-1:0] BACKGROUND   = {DATA_W{1'b0}},
    parameter bit                STOP_ON_FAIL = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_syndrome,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int unsigned       ELEM_W    = 3;
    localparam logic [ELEM_W-1:0] ELEM_END  = ELEM_W'(6);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                second_q, second_d;
    logic                csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ELEM_W-1:0]   rd_elem_q, rd_elem_d;
    logic [DATA_W-1:0]   rd_exp_q, rd_exp_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [ELEM_W-1:0]   cmp_elem_q, cmp_elem_d;
    logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
    logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [ELEM_W-1:0]   fail_elem_q, fail_elem_d;
    logic [DATA_W-1:0]   fail_syn_q, fail_syn_d;

    logic                issue_c, op_read_c, op_down_c, mismatch_c;
    logic [ELEM_W-1:0]   op_elem_c;
    logic [ADDR_W-1:0]   op_addr_c;
    logic                op_second_c;

    // Next-state, op issue, compare pipeline and failure capture
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        second_d    = second_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        oeb_d       = 1'b1;
        a_d         = '0;
        wdata_d     = '0;
        rd_valid_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_elem_d   = rd_elem_q;
        rd_exp_d    = rd_exp_q;
        cmp_valid_d = rd_valid_q;
        cmp_addr_d  = rd_addr_q;
        cmp_elem_d  = rd_elem_q;
        cmp_exp_d   = rd_exp_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_syn_d  = fail_syn_q;
        issue_c     = 1'b0;
        op_elem_c   = elem_q;
        op_addr_c   = addr_q;
        op_second_c = second_q;
        mismatch_c  = cmp_valid_q && (sram_o != cmp_exp_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_syn_d  = '0;
                    issue_c     = 1'b1;
                    op_elem_c   = '0;
                    op_addr_c   = '0;
                    op_second_c = 1'b0;
                end
            end
            ST_RUN: begin
                if (elem_q == ELEM_END) state_d = ST_DRAIN;
                else                    issue_c = 1'b1;
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        op_read_c = (op_elem_c != '0) && !op_second_c;
        op_down_c = (op_elem_c == ELEM_W'(3)) || (op_elem_c == ELEM_W'(4));

        if (issue_c) begin
            csb_d = 1'b0;
            a_d   = op_addr_c;
            if (op_read_c) begin
                oeb_d      = 1'b0;
                rd_valid_d = 1'b1;
                rd_addr_d  = op_addr_c;
                rd_elem_d  = op_elem_c;
                rd_exp_d   = ((op_elem_c == ELEM_W'(2)) || (op_elem_c == ELEM_W'(4)))
                             ? ~BACKGROUND : BACKGROUND;
            end else begin
                web_d   = 1'b0;
                wdata_d = ((op_elem_c == ELEM_W'(1)) || (op_elem_c == ELEM_W'(3)))
                          ? ~BACKGROUND : BACKGROUND;
            end
            // Read of a pair stays on its address; otherwise step or move to next element
            if (op_read_c && (op_elem_c != ELEM_W'(5))) begin
                elem_d   = op_elem_c;
                addr_d   = op_addr_c;
                second_d = 1'b1;
            end else begin
                second_d = 1'b0;
                if (op_down_c ? (op_addr_c == '0) : (op_addr_c == ADDR_LAST)) begin
                    elem_d = op_elem_c + ELEM_W'(1);
                    addr_d = ((op_elem_c == ELEM_W'(2)) || (op_elem_c == ELEM_W'(3)))
                             ? ADDR_LAST : '0;
                end else begin
                    elem_d = op_elem_c;
                    addr_d = op_down_c ? (op_addr_c - ADDR_W'(1)) : (op_addr_c + ADDR_W'(1));
                end
            end
        end

        if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && mismatch_c && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
            fail_syn_d  = sram_o ^ cmp_exp_q;
            if (STOP_ON_FAIL) begin
                state_d     = ST_DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                csb_d       = 1'b1;
                web_d       = 1'b1;
                oeb_d       = 1'b1;
                a_d         = '0;
                wdata_d     = '0;
                rd_valid_d  = 1'b0;
                cmp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            second_q    <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            a_q         <= '0;
            wdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            rd_exp_q    <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            cmp_exp_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_syn_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            second_q    <= second_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            a_q         <= a_d;
            wdata_q     <= wdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_elem_q   <= rd_elem_d;
            rd_exp_q    <= rd_exp_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            cmp_exp_q   <= cmp_exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_syn_q  <= fail_syn_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_elem     = fail_elem_q;
    assign fail_syndrome = fail_syn_q;
    assign sram_csb      = csb_q;
    assign sram_web      = web_q;
    assign sram_oeb      = oeb_q;
    assign sram_a        = a_q;
    assign sram_i        = wdata_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two DUTs (abort-on-fail and run-to-end) each on a
// faultable SRAM model, checked cycle by cycle against a March C- reference.
module tb_sram_march_bist;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 34;
    localparam int unsigned DEPTH  = 64;
    localparam int          NOPS   = 640;
    localparam int unsigned PIN_W  = 3 + ADDR_W + DATA_W;
    localparam int unsigned FAIL_W = 1 + ADDR_W + 3 + DATA_W;
    localparam logic [DATA_W-1:0] ZEROS     = '0;
    localparam logic [DATA_W-1:0] ONES      = '1;
    localparam logic [PIN_W-1:0]  IDLE_PINS = {3'b111, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};

    logic clock     = 1'b0;
    logic reset_n   = 1'b0;
    logic start_drv = 1'b0;
    int   sel       = 0;

    logic              f_en   [2];
    logic [ADDR_W-1:0] f_addr [2];
    logic [DATA_W-1:0] f_mask [2];
    logic              f_sa1  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Stuck-at fault applied to the read port of the faulty word
    function automatic logic [DATA_W-1:0] fault_view(input logic [DATA_W-1:0] d, input logic hit,
                                                     input logic [DATA_W-1:0] m, input logic sa1);
        if (!hit) return d;
        return sa1 ? (d | m) : (d & ~m);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic              busy, done, fail, csb, web, oeb;
        logic [ADDR_W-1:0] fail_addr, a;
        logic [2:0]        fail_elem;
        logic [DATA_W-1:0] fail_syn, wdata;
        logic [DATA_W-1:0] rdata = '0;
        logic [DATA_W-1:0] mem [DEPTH];

        sram_march_bist #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
            .BACKGROUND(ZEROS), .STOP_ON_FAIL(g == 0)
        ) u_dut (
            .clock(clock), .reset_n(reset_n), .start(start_drv && (sel == g)),
            .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
            .fail_elem(fail_elem), .fail_syndrome(fail_syn),
            .sram_csb(csb), .sram_web(web), .sram_oeb(oeb), .sram_a(a),
            .sram_i(wdata), .sram_o(rdata)
        );

        always @(posedge clock) begin
            if (!csb) begin
                if (!web)      mem[a] <= wdata;
                else if (!oeb) rdata  <= fault_view(mem[a], f_en[g] && (a == f_addr[g]),
                                                    f_mask[g], f_sa1[g]);
            end
        end
    end

    logic              obs_busy, obs_done;
    logic [PIN_W-1:0]  obs_pins;
    logic [FAIL_W-1:0] obs_fail;

    always_comb begin
        if (sel == 1) begin
            obs_busy = g_dut[1].busy;
            obs_done = g_dut[1].done;
            obs_pins = {g_dut[1].csb, g_dut[1].web, g_dut[1].oeb, g_dut[1].a, g_dut[1].wdata};
            obs_fail = {g_dut[1].fail, g_dut[1].fail_addr, g_dut[1].fail_elem, g_dut[1].fail_syn};
        end else begin
            obs_busy = g_dut[0].busy;
            obs_done = g_dut[0].done;
            obs_pins = {g_dut[0].csb, g_dut[0].web, g_dut[0].oeb, g_dut[0].a, g_dut[0].wdata};
            obs_fail = {g_dut[0].fail, g_dut[0].fail_addr, g_dut[0].fail_elem, g_dut[0].fail_syn};
        end
    end

    // Reference results: expected pin activity per op and the first failure
    logic [PIN_W-1:0]  exp_pins [NOPS];
    bit                exp_rd   [NOPS];
    logic              m_fail;
    int                m_fail_op;
    logic [2:0]        m_elem;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_syn;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pins"}, 64'(obs_pins), 64'(IDLE_PINS));
        chk({tag, "_status"}, 64'({obs_busy, obs_done, obs_fail}), 64'(0));
    endtask

    task automatic model_run(input logic fen, input logic [ADDR_W-1:0] fa,
                             input logic [DATA_W-1:0] fm, input logic fs);
        logic [DATA_W-1:0] m [DEPTH];
        logic [DATA_W-1:0] expv, obs, wv;
        logic [ADDR_W-1:0] a;
        int n = 0;
        m_fail = 1'b0; m_fail_op = -1; m_elem = '0; m_addr = '0; m_syn = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                a = ADDR_W'((e == 3 || e == 4) ? (int'(DEPTH) - 1 - i) : i);
                if (e != 0) begin
                    expv = (e == 2 || e == 4) ? ONES : ZEROS;
                    obs  = fault_view(m[a], fen && (a == fa), fm, fs);
                    exp_pins[n] = {3'b010, a, ZEROS};
                    exp_rd[n]   = 1'b1;
                    if ((obs !== expv) && !m_fail) begin
                        m_fail = 1'b1; m_fail_op = n; m_elem = 3'(e); m_addr = a; m_syn = obs ^ expv;
                    end
                    n++;
                end
                if (e != 5) begin
                    wv = (e == 1 || e == 3) ? ONES : ZEROS;
                    m[a] = wv;
                    exp_pins[n] = {3'b001, a, wv};
                    exp_rd[n]   = 1'b0;
                    n++;
                end
            end
        end
    endtask

    task automatic run_test(input int s, input logic fen, input int fa, input int fb,
                            input logic fs, input int abort_at);
        int done_edge, last_op, p3, nrd, nwr, erd, ewr;
        logic stop;
        logic [DATA_W-1:0] mask;
        mask = ZEROS;
        mask[fb] = 1'b1;
        sel = s;
        f_en[s] = fen; f_addr[s] = ADDR_W'(fa); f_mask[s] = mask; f_sa1[s] = fs;
        model_run(fen, ADDR_W'(fa), mask, fs);
        stop      = (s == 0) && m_fail;
        done_edge = stop ? m_fail_op + 2 : NOPS + 1;
        last_op   = stop ? ((m_fail_op + 1 < NOPS) ? m_fail_op + 1 : NOPS - 1) : NOPS - 1;
        erd = 0; ewr = 0; nrd = 0; nwr = 0;
        for (int i = 0; i <= last_op; i++) begin
            if (exp_rd[i]) erd++;
            else           ewr++;
        end
        p3 = $urandom_range(20, 600);
        @(negedge clock);
        start_drv = 1'b1;
        for (int k = 0; k <= done_edge + 1; k++) begin
            @(negedge clock);
            start_drv = (k + 1 < done_edge) && (k == 10 || k == 200 || k == p3);
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_idle("reset_async");
                @(negedge clock);
                check_idle("reset_held");
                @(negedge clock);
                reset_n   = 1'b1;
                start_drv = 1'b0;
                return;
            end
            if (k == 0) chk("fail_cleared", 64'(obs_fail), 64'(0));
            if (k <= last_op) chk($sformatf("pins_c%0d", k), 64'(obs_pins), 64'(exp_pins[k]));
            else              chk($sformatf("pins_c%0d", k), 64'(obs_pins), 64'(IDLE_PINS));
            chk($sformatf("busy_done_c%0d", k), 64'({obs_busy, obs_done}),
                64'({k < done_edge, k >= done_edge}));
            if (!obs_pins[PIN_W-1]) begin
                if (!obs_pins[PIN_W-3])      nrd++;
                else if (!obs_pins[PIN_W-2]) nwr++;
            end
        end
        start_drv = 1'b0;
        chk("fail_info", 64'(obs_fail), 64'({m_fail, m_addr, m_elem, m_syn}));
        chk("n_reads", 64'(nrd), 64'(erd));
        chk("n_writes", 64'(nwr), 64'(ewr));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            f_en[i] = 1'b0; f_addr[i] = '0; f_mask[i] = '0; f_sa1[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        check_idle("rst_a");
        sel = 1;
        #1;
        check_idle("rst_b");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_idle("idle_b");

        run_test(0, 1'b0, 0, 0, 1'b0, -1);
        run_test(0, 1'b1, 17, 5, 1'b1, -1);
        run_test(1, 1'b1, 17, 5, 1'b1, -1);
        run_test(1, 1'b0, 0, 0, 1'b0, 300);
        run_test(1, 1'b0, 0, 0, 1'b0, -1);
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 4)) @(negedge clock);
            run_test(t % 2, 1'b1, $urandom_range(0, 63), $urandom_range(0, 33),
                     1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test initiator for one single-port 1RW SRAM macro with 64 words of 34 bits.
- Drives the macro's active-low chip-select, write-enable and output-enable, plus address and write-data pins.
- Runs a March C- sequence, checks read data, and reports pass/fail with first-failure diagnostics.
- Sits between the test/control CSR block and the SRAM; the macro is clocked by the same clock.

Parameters:
- ADDR_W, 6, SRAM address width.
- DATA_W, 34, SRAM word width.
- DEPTH, 64, number of words; highest address is DEPTH-1.
- BACKGROUND, {DATA_W{1'b0}}, data written for "0"; "1" is ~BACKGROUND.
- STOP_ON_FAIL, 1, 1 = abort at first mismatch; 0 = run to completion, keeping the first failure only.

Ports:
- clock  in  1  Rising-edge clock, shared with the SRAM clock pin.
- reset_n  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle request to begin a test. Ignored while busy.
- busy  out  1  High while a test is running.
- done  out  1  Sticky; set at test end, cleared by the next accepted start.
- fail  out  1  Sticky; valid when done=1.
- fail_addr  out  ADDR_W  Address of the first mismatch.
- fail_elem  out  3  March element (1..5) of the first mismatch.
- fail_syndrome  out  DATA_W  Read data XOR expected, for the first mismatch.
- sram_csb  out  1  Chip select, active low.
- sram_web  out  1  Write enable, active low.
- sram_oeb  out  1  Read enable, active low.
- sram_a  out  ADDR_W  Address.
- sram_i  out  DATA_W  Write data.
- sram_o  in  DATA_W  Read data, registered in the SRAM and valid the cycle after a read is issued.

Behaviour:
- Reset and idle values: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_syndrome=0; sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0. All SRAM control outputs are driven from flops.
- States: IDLE -> RUN -> DRAIN -> DONE.
  - DONE accepts start and goes back to RUN, clearing done, fail and all fail_* outputs.
- March elements, issued one op per cycle:
  - E0 up: w0.
  - E1 up: r0, w1.
  - E2 up: r1, w0.
  - E3 down: r0, w1.
  - E4 down: r1, w0.
  - E5 up: r0.
  - Up runs addresses 0..DEPTH-1; down runs DEPTH-1..0.
  - Read/write pairs go to the same address in consecutive cycles.
- Op encoding:
  - Write: csb=0, web=0, oeb=1, sram_i = pattern.
  - Read: csb=0, web=1, oeb=0, sram_i = 0.
  - Read and write are never asserted in the same cycle.
- Timing, with start sampled high at edge 0:
  - Ops are presented after edges 0..639; 640 ops total: 64 + 4×128 + 64.
  - DRAIN occupies the cycle after edge 640, with csb=1.
  - done=1 and busy=0 appear after edge 641.
  - busy=1 from after edge 0 until after edge 641.
- Compare pipeline:
  - The read address, element and expected data are registered alongside the read.
  - In the following cycle, sram_o is compared to the expected data, unless that cycle follows a write (no compare valid).
  - Only the first mismatch updates fail_*; later mismatches never overwrite it.
- STOP_ON_FAIL=1: at the edge that registers a mismatch, the FSM goes straight to DONE with fail=1 and busy=0, and forces csb=1.
  - An op issued in that same cycle may already have executed; this is acceptable.
- Counter wrap: the address counter reaching DEPTH-1 (up) or 0 (down) on the element's last op advances to the next element with a fresh start address. No wrap-around artefacts.
- reset_n low mid-run: everything returns to idle values immediately; done is not set, and the SRAM contents are undefined.
- start while busy=1: ignored, no effect on the run or counters.
- start held high across DONE: exactly one new run begins per accepted edge.

Test Plan:
- Good memory: start pulse -> busy high for 641 cycles, then done=1, fail=0; exactly 320 reads and 320 writes observed on the SRAM pins.
- Sequence check: monitor the pins.
  - First 64 ops are writes of 34'h0 to addresses 0..63.
  - Op 64 is a read of address 0; op 65 writes 34'h3FFFFFFFF to address 0.
  - Ops 320..447 (E3) read/write addresses 63 down to 0.
- Stuck-at-1 on bit 5 of word 17, STOP_ON_FAIL=1:
  - Required: fail=1, fail_elem=1, fail_addr=17, fail_syndrome=34'h20.
  - done is asserted 2 cycles after the faulty read is issued.
- Same fault with STOP_ON_FAIL=0: the run lasts the full 641 cycles, and fail_* keep the first failure (elem 1, addr 17) despite later mismatches in E3 and E5.
- reset_n low at cycle 300 for 2 cycles, then start -> all outputs at idle values during reset; a full clean run afterwards with done at +641 and fail=0.
- start pulsed at cycles 10 and 200 of a run -> both ignored, done still at +641; a start in DONE clears done and fail in the next cycle.
